// File: rtl/imem_program_sequencer.sv
// ============================================================================
// imem_program_sequencer : instruction store with LOAD/RUN/HALT sequencing
// Optional macro IMEM_FAULT_EN adds a sticky fetch-fault output.  Rev 1.0
// ============================================================================
`default_nettype none

module imem_program_sequencer #(
  parameter int          DEPTH      = 8,
  parameter int          AW         = $clog2(DEPTH),
  parameter int          RUN_CYCLES = 21,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          start,
  input  logic          restart,
  output logic          core_reset,
  input  logic          imem_req_valid,
  input  logic [31:0]   imem_req_addr,
  output logic [31:0]   imem_resp_data,
  output logic          running,
  output logic          done,
  output logic [31:0]   cycle_count
`ifdef IMEM_FAULT_EN
  ,
  output logic          fault
`endif
);

  localparam logic [1:0]  ST_LOAD = 2'd0;
  localparam logic [1:0]  ST_RUN  = 2'd1;
  localparam logic [1:0]  ST_HALT = 2'd2;

  localparam bit          BOUNDED  = (RUN_CYCLES != 0);
  localparam logic [31:0] RUN_LAST = 32'(RUN_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   cycle_count_q, cycle_count_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  logic          load_fire;
  logic          fetch_valid;
  logic          bad_fetch;
  logic          run_limit_hit;
  logic [AW-1:0] fetch_idx;

  assign load_fire     = (state_q == ST_LOAD) && ld_valid;
  assign fetch_valid   = (state_q == ST_RUN) && imem_req_valid;
  assign fetch_idx     = imem_req_addr[AW+1:2];
  assign run_limit_hit = BOUNDED && (cycle_count_q == RUN_LAST);

`ifdef IMEM_FAULT_EN
  logic fault_q, fault_d;

  // Any address outside the word-aligned store window is a fault.
  assign bad_fetch = fetch_valid &&
                     ((imem_req_addr[31:AW+2] != '0) || (imem_req_addr[1:0] != 2'b00));

  always_comb begin
    fault_d = fault_q;
    if ((state_q == ST_RUN) && bad_fetch) begin
      fault_d = 1'b1;
    end else if ((state_q == ST_HALT) && restart) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  // Upper and byte-offset address bits are deliberately ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_req_addr[31:AW+2], imem_req_addr[1:0]};
  assign bad_fetch        = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; encoding 3 falls back to LOAD
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (start) state_d = ST_RUN;
      ST_RUN:  if (run_limit_hit || bad_fetch) state_d = ST_HALT;
      ST_HALT: if (restart) state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  // Output decode
  always_comb begin
    ld_ready   = 1'b0;
    core_reset = 1'b1;
    running    = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_LOAD: ld_ready = 1'b1;
      ST_RUN: begin
        core_reset = 1'b0;
        running    = 1'b1;
      end
      ST_HALT: done = 1'b1;
      default: ;
    endcase
  end

  // Run-cycle counter, saturating
  always_comb begin
    cycle_count_d = cycle_count_q;
    if ((state_q == ST_LOAD) && start) begin
      cycle_count_d = '0;
    end else if ((state_q == ST_RUN) && (cycle_count_q != 32'hFFFF_FFFF)) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cycle_count = cycle_count_q;

  // Instruction store: written only by accepted loads
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (load_fire) begin
      mem_d[ld_addr] = ld_data;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset) begin
        mem_q[i] <= NOP_WORD;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign imem_resp_data = (fetch_valid && !bad_fetch) ? mem_q[fetch_idx] : NOP_WORD;

endmodule

`default_nettype wire

// File: tb/tb_imem_program_sequencer.sv
// Directed self-checking bench for imem_program_sequencer.
`default_nettype none

module tb_imem_program_sequencer;

  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          start;
  logic          restart;
  logic          core_reset;
  logic          imem_req_valid;
  logic [31:0]   imem_req_addr;
  logic [31:0]   imem_resp_data;
  logic          running;
  logic          done;
  logic [31:0]   cycle_count;
`ifdef IMEM_FAULT_EN
  logic          fault;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  imem_program_sequencer #(
    .DEPTH(8), .RUN_CYCLES(21), .NOP_WORD(32'h00000013)
  ) dut (
    .clock(clock), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .restart(restart), .core_reset(core_reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_resp_data(imem_resp_data), .running(running), .done(done),
    .cycle_count(cycle_count)
`ifdef IMEM_FAULT_EN
    , .fault(fault)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    imem_req_valid = 1'b1;
    imem_req_addr  = addr;
    #1;
    check(tag, imem_resp_data, exp);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; restart = 1'b0; imem_req_valid = 1'b0; imem_req_addr = '0;
    tick(); tick();

    // Reset state
    check("rst_ld_ready",   {31'd0, ld_ready},   32'd1);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_running",    {31'd0, running},    32'd0);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_cycle",      cycle_count,         32'd0);
    reset = 1'b1;
    tick();

    // Test 1: load program, start
    load(3'd0, 32'h00000013);
    load(3'd1, 32'h00200093);
    load(3'd2, 32'h00102223);
    load(3'd3, 32'h00402103);
    fetch("load_fetch_nop", 32'h4, 32'h00000013);
    start = 1'b1; tick(); start = 1'b0;
    check("run_core_reset", {31'd0, core_reset}, 32'd0);
    check("run_running",    {31'd0, running},    32'd1);
    check("run_cycle0",     cycle_count,         32'd0);
    fetch("fetch_0x0",  32'h0,  32'h00000013);
    fetch("fetch_0x4",  32'h4,  32'h00200093);
    fetch("fetch_0x8",  32'h8,  32'h00102223);
    fetch("fetch_0xc",  32'hC,  32'h00402103);
    fetch("fetch_wrap", 32'h24, 32'h00200093);
    imem_req_valid = 1'b0; #1;
    check("fetch_novalid", imem_resp_data, 32'h00000013);

    // Test 2: bounded run length
    n = 1;
    tick();
    while (running && n < 60) begin
      n++;
      tick();
    end
    check("run_length",      n,                   32'd21);
    check("halt_done",       {31'd0, done},       32'd1);
    check("halt_cycle",      cycle_count,         32'd21);
    check("halt_core_reset", {31'd0, core_reset}, 32'd1);
    check("halt_ld_ready",   {31'd0, ld_ready},   32'd0);
    start = 1'b1; tick(); start = 1'b0; tick();
    check("halt_start_ign",  {31'd0, done},       32'd1);
    check("halt_cycle_hold", cycle_count,         32'd21);
    fetch("halt_fetch_nop", 32'h4, 32'h00000013);

    restart = 1'b1; tick(); restart = 1'b0;
    check("restart_ld_ready", {31'd0, ld_ready}, 32'd1);
    check("restart_done",     {31'd0, done},     32'd0);
    check("restart_cycle",    cycle_count,       32'd21);

    // Test 3: load and start together
    ld_valid = 1'b1; ld_addr = 3'd5; ld_data = 32'hDEADBEEF; start = 1'b1;
    tick();
    ld_valid = 1'b0; start = 1'b0;
    check("ldstart_running", {31'd0, running}, 32'd1);
    fetch("fetch_0x14", 32'h14, 32'hDEADBEEF);
    fetch("retained_0x4", 32'h4, 32'h00200093);
    ld_valid = 1'b1; ld_addr = 3'd5; ld_data = 32'h0; tick(); ld_valid = 1'b0;
    fetch("run_load_ign", 32'h14, 32'hDEADBEEF);

    // Test 5: reset mid-run at cycle_count 7
    n = 0;
    while (cycle_count != 32'd7 && n < 40) begin
      n++;
      tick();
    end
    check("reach_cycle7", cycle_count, 32'd7);
    reset = 1'b0; tick(); reset = 1'b1;
    check("mid_rst_running",    {31'd0, running},    32'd0);
    check("mid_rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("mid_rst_ld_ready",   {31'd0, ld_ready},   32'd1);
    check("mid_rst_cycle",      cycle_count,         32'd0);
    restart = 1'b1; tick(); restart = 1'b0;
    check("load_restart_ign", {31'd0, ld_ready}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    fetch("cleared_0x4",  32'h4,  32'h00000013);
    fetch("cleared_0x14", 32'h14, 32'h00000013);
    fetch("cleared_0xc",  32'hC,  32'h00000013);

`ifdef IMEM_FAULT_EN
    // Test 6: misaligned fetch faults
    fetch("fault_resp", 32'h00000102, 32'h00000013);
    tick();
    imem_req_valid = 1'b0;
    check("fault_set",  {31'd0, fault}, 32'd1);
    check("fault_done", {31'd0, done},  32'd1);
    restart = 1'b1; tick(); restart = 1'b0;
    check("fault_clear", {31'd0, fault}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_program_sequencer.md
Name: imem_program_sequencer

Overview:
- Owns a small instruction store feeding the core's fetch port (imem_req_addr / imem_resp_data).
- Sequences each run as LOAD, RUN, HALT:
  - LOAD: a host loads a program while the core is held in reset.
  - RUN: releases the core for a bounded number of cycles.
  - HALT: parks the core and reports completion.
- Sits between the bench/host and the core top, replacing a hard-wired program array.

Parameters:
- DEPTH, 8, number of 32-bit instruction words; power of two, ≥2.
- AW, $clog2(DEPTH), word-index width.
- RUN_CYCLES, 21, cycles the core runs before HALT; 0 means unbounded.
- NOP_WORD, 32'h00000013, word returned for any fetch outside RUN and used as the memory clear value.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-low; asserted when 0, sampled on rising clock.
- ld_valid  in  1  host load request.
- ld_ready  out  1  load accepted this cycle when ld_valid && ld_ready.
- ld_addr  in  AW  word index to write.
- ld_data  in  32  instruction word.
- start  in  1  pulse: LOAD→RUN.
- restart  in  1  pulse: HALT→LOAD.
- core_reset  out  1  active-high reset to core (CoreTop polarity).
- imem_req_valid  in  1  core fetch valid.
- imem_req_addr  in  32  core byte fetch address.
- imem_resp_data  out  32  fetched instruction, same cycle.
- running  out  1  state == RUN.
- done  out  1  state == HALT.
- cycle_count  out  32  cycles spent in RUN for the current or last run.

Behaviour:
- Reset (reset==0 at edge):
  - state=LOAD, every mem entry=NOP_WORD, cycle_count=0.
  - Outputs after the edge: ld_ready=1, core_reset=1, running=0, done=0.
  - Reset overrides everything, including mid-RUN.
- States (2-bit): LOAD=0, RUN=1, HALT=2. The value 3 is illegal and decodes to LOAD on the next edge.
- LOAD:
  - ld_ready=1, core_reset=1.
  - Accepted load writes mem[ld_addr]<=ld_data at that edge. Writes to the same address in consecutive cycles keep the last one.
  - start=1 → RUN next edge, cycle_count<=0. If ld_valid and start are both high in the same cycle, the write commits and the transition happens on the same edge.
- RUN:
  - ld_ready=0, core_reset=0, running=1. Loads are ignored with no side effects.
  - cycle_count increments by 1 each RUN cycle and saturates at 32'hFFFFFFFF.
  - If RUN_CYCLES≠0 and cycle_count==RUN_CYCLES-1: → HALT next edge, and cycle_count ends at RUN_CYCLES.
  - start is ignored.
- HALT:
  - core_reset=1, done=1, ld_ready=0, cycle_count holds.
  - restart=1 → LOAD next edge. Memory is retained; cycle_count is unchanged until the next start.
  - start is ignored.
  - In LOAD and RUN, restart is ignored.
- Fetch (combinational, zero latency):
  - imem_resp_data = mem[imem_req_addr[AW+1:2]] when running && imem_req_valid, else NOP_WORD.
  - Upper address bits wrap modulo DEPTH (matching the existing addr[4:2] indexing). Bits [1:0] are ignored.
- Memory is never written outside LOAD. No read/write hazard is possible, since reads only occur in RUN.

Optional Feature:
- Macro: IMEM_FAULT_EN.
- Defined:
  - Adds output fault (1 bit, reset 0).
  - In RUN, a valid fetch with imem_req_addr[31:AW+2]≠0 or imem_req_addr[1:0]≠0 returns NOP_WORD, sets fault=1 sticky, and forces HALT on the next edge.
  - fault clears only on reset or on a restart from HALT.
- Undefined:
  - No fault port.
  - Addresses wrap modulo DEPTH with no check, as described above.

Test Plan:
1. Reset, then load words 0..3 = 13, 00200093, 00102223, 00402103; pulse start.
   - mem holds the values.
   - core_reset falls the edge after start.
   - Fetch addr 0x4 → 32'h00200093 the same cycle.
2. RUN_CYCLES=21, start at cycle T.
   - running is high for exactly 21 cycles.
   - done rises at T+22 edge; cycle_count=21 and holds; core_reset=1.
3. ld_valid with start in the same LOAD cycle (addr 5, data DEADBEEF).
   - The write commits.
   - A fetch of 0x14 in RUN returns DEADBEEF.
   - ld_valid asserted in RUN leaves mem unchanged.
4. Fetch 0x24 with DEPTH=8 and the macro off → returns mem[1]. Fetch in LOAD or HALT, or with imem_req_valid=0 → 32'h00000013.
5. reset=0 mid-RUN at cycle_count=7.
   - Next edge: state LOAD, all entries NOP_WORD, cycle_count=0, core_reset=1.
   - restart then start, without reloading, executes NOPs only.
6. IMEM_FAULT_EN defined, fetch 0x00000102 in RUN.
   - resp=NOP_WORD; fault=1 and done=1 on the next edge.
   - restart clears fault.
